mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port synchronous memory (1-cycle read latency) between the core's
//   instruction-fetch port and data (MEM-stage) port, enabling a unified imem/dmem.
//   Grants at most one access per cycle, routes each read response back to its owner and
//   bounds fetch starvation. Sits between the pipeline's IF/MEM stages and the memory.
// PARAMETERS
//   AW          17  word-address width of the shared memory
//   DW          32  data width
//   STARVE_MAX   3  consecutive denied fetch cycles before fetch wins a conflict (0 = fetch always wins)
// PORTS
//   clk        in   1   clock, all state updates on rising edge
//   rst        in   1   asynchronous, active-low reset
//   halt       in   1   freeze: no new grants while high (exception in WB)
//   i_req      in   1   fetch request
//   i_addr     in   AW  fetch word address
//   i_gnt      out  1   fetch accepted this cycle
//   i_rvalid   out  1   fetch data valid on i_rdata
//   i_rdata    out  DW  fetch read data
//   d_req      in   1   data request
//   d_we       in   1   data write enable
//   d_width    in   3   access width code, passed to memory unchanged
//   d_addr     in   AW  data word address
//   d_wdata    in   DW  data write value
//   d_gnt      out  1   data access accepted this cycle
//   d_rvalid   out  1   data response valid (reads and write acks)
//   d_rdata    out  DW  data read data
//   m_addr     out  AW  memory address
//   m_width    out  3   memory width code
//   m_we       out  1   memory write enable
//   m_wdata    out  DW  memory write data
//   m_rdata    in   DW  memory read data, valid 1 cycle after address
//   conflicts  out  32  count of cycles with i_req & d_req & !halt
// BEHAVIOUR
//   - Reset (rst low, async): owner=NONE, starve_cnt=0, conflicts=0; i_gnt, d_gnt, m_we,
//     i_rvalid, d_rvalid all 0 while rst low. In-flight response is discarded.
//   - Grant (combinational, same cycle): halt -> none. Only one req -> that port.
//     Both req -> fetch if starve_cnt==STARVE_MAX, else data.
//   - At most one of i_gnt/d_gnt high. Request may drop without grant; no request is latched.
//   - Memory drive: fetch grant -> m_addr=i_addr, m_width=3'b010, m_we=0.
//     Data grant -> m_addr/m_width/m_wdata/m_we from d_*. No grant -> m_we=0, m_addr=i_addr.
//   - owner register (NONE/INSTR/DATA) <= granted port each edge; NONE if no grant.
//   - Response: i_rvalid = (owner==INSTR), d_rvalid = (owner==DATA); exactly 1-cycle latency.
//     i_rdata = d_rdata = m_rdata unconditionally; only rvalid qualifies. Back-to-back grants
//     give one response per cycle, fully pipelined.
//   - halt: blocks new grants only; response to last pre-halt grant still delivered.
//   - starve_cnt (saturating at STARVE_MAX): +1 when i_req & !i_gnt & !halt; cleared when
//     i_gnt or !i_req; held while halt.
//   - conflicts: +1 per cycle with i_req & d_req & !halt; wraps 2^32-1 -> 0.
// TESTING
//   - Reset: drive reqs during rst low -> no gnt, no rvalid, m_we=0; release -> grants start next cycle.
//   - Solo fetch, addrs 0,1,2 back-to-back -> i_gnt each cycle, i_rvalid 1 cycle later, data in order.
//   - Continuous both reqs, STARVE_MAX=3 -> pattern D,D,D,I repeating; conflicts +1 per cycle.
//   - Data write addr 5 = 0xDEADBEEF then read 5 -> d_rvalid ack, read returns 0xDEADBEEF.
//   - halt raised cycle after fetch grant -> i_rvalid still pulses once; no gnt while halt;
//     starve_cnt holds.
//   - rst asserted mid-stream with owner=DATA -> d_rvalid never asserts for that access.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-port synchronous memory.
// The data port wins conflicts unless fetch has been denied STARVE_MAX cycles in a row.
module mem_port_arbiter #(
  parameter int unsigned AW         = 17,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_width,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] m_addr,
  output logic [2:0]    m_width,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [31:0]   conflicts
);

  localparam int unsigned   SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  owner_e        owner_r;
  logic [SW-1:0] starve_cnt_r;
  logic [31:0]   conflicts_r;
  logic          i_gnt_s;
  logic          d_gnt_s;
  logic          i_rvalid_s;
  logic          d_rvalid_s;

  // Same-cycle grant decision; a starved fetch overrides the data priority.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (!rst || halt) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (i_req && d_req) begin
      if (starve_cnt_r == STARVE_LIM) begin
        i_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else if (i_req) begin
      i_gnt_s = 1'b1;
    end else if (d_req) begin
      d_gnt_s = 1'b1;
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // Memory-side mux; an idle cycle parks the address on the fetch port.
  always_comb begin
    m_addr  = i_addr;
    m_width = 3'b010;
    m_we    = 1'b0;
    m_wdata = d_wdata;
    if (d_gnt_s) begin
      m_addr  = d_addr;
      m_width = d_width;
      m_we    = d_we;
    end else begin
      m_addr  = i_addr;
      m_width = 3'b010;
      m_we    = 1'b0;
    end
  end

  // Owner tracking, fetch starvation counter and conflict statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r      <= OWN_NONE;
      starve_cnt_r <= {SW{1'b0}};
      conflicts_r  <= 32'd0;
    end else begin
      if (i_gnt_s) begin
        owner_r <= OWN_INSTR;
      end else if (d_gnt_s) begin
        owner_r <= OWN_DATA;
      end else begin
        owner_r <= OWN_NONE;
      end

      // halt freezes the count so a frozen pipeline cannot build up fetch priority
      if (halt) begin
        starve_cnt_r <= starve_cnt_r;
      end else if (i_gnt_s || !i_req) begin
        starve_cnt_r <= {SW{1'b0}};
      end else if (starve_cnt_r != STARVE_LIM) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end

      if (i_req && d_req && !halt) begin
        conflicts_r <= conflicts_r + 32'd1;
      end else begin
        conflicts_r <= conflicts_r;
      end
    end
  end

  // Response routing follows the owner of the previous cycle's access.
  always_comb begin
    i_rvalid_s = 1'b0;
    d_rvalid_s = 1'b0;
    case (owner_r)
      OWN_INSTR: i_rvalid_s = 1'b1;
      OWN_DATA:  d_rvalid_s = 1'b1;
      default: begin
        i_rvalid_s = 1'b0;
        d_rvalid_s = 1'b0;
      end
    endcase
  end

  assign i_gnt     = i_gnt_s;
  assign d_gnt     = d_gnt_s;
  assign i_rvalid  = i_rvalid_s;
  assign d_rvalid  = d_rvalid_s;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign conflicts = conflicts_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
module tb_mem_port_arbiter;
  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, halt, i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [2:0]    d_width, m_width;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata, m_wdata, m_rdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_we;
  logic [31:0]   conflicts;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:255];
  logic [255:0]  wr_mask;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_width(m_width), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  // Unwritten words read back as 0xA000_0000 | address.
  always @(posedge clk) begin
    if (!rst) begin
      wr_mask <= '0;
    end else if (m_we) begin
      mem[m_addr[7:0]]     <= m_wdata;
      wr_mask[m_addr[7:0]] <= 1'b1;
    end
    m_rdata <= wr_mask[m_addr[7:0]] ? mem[m_addr[7:0]] : (32'hA000_0000 | {24'd0, m_addr[7:0]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; halt = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = '0; d_addr = 17'd3; d_width = 3'b010; d_wdata = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      tick(); #3;
      checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got i=%0b d=%0b exp 0 0", i_gnt, d_gnt); end
      checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL reset_m_we got %0b exp 0", m_we); end
      checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got i=%0b d=%0b exp 0 0", i_rvalid, d_rvalid); end
    end
    checks++; if (conflicts !== 32'd0) begin errors++; $display("FAIL reset_conflicts got %0d exp 0", conflicts); end
    tick();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_solo_fetch();
    for (int k = 0; k < 4; k++) begin
      tick();
      i_req = (k < 3); i_addr = 17'(k);
      #3;
      if (k < 3) begin
        checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt k=%0d got i=%0b d=%0b exp 1 0", k, i_gnt, d_gnt); end
        checks++; if (m_addr !== 17'(k) || m_width !== 3'b010 || m_we !== 1'b0) begin errors++; $display("FAIL fetch_mem k=%0d got addr=%0d w=%0b we=%0b", k, m_addr, m_width, m_we); end
      end
      if (k > 0) begin
        checks++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid k=%0d got i=%0b d=%0b exp 1 0", k, i_rvalid, d_rvalid); end
        checks++; if (i_rdata !== (32'hA000_0000 + 32'(k - 1))) begin errors++; $display("FAIL fetch_rdata k=%0d got %h exp %h", k, i_rdata, 32'hA000_0000 + 32'(k - 1)); end
      end else begin
        checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_first_rvalid got %0b exp 0", i_rvalid); end
      end
    end
    tick(); #3;
    checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_idle_rvalid got %0b exp 0", i_rvalid); end
  endtask

  task automatic test_conflict();
    logic [7:0] pat;
    pat = 8'b1000_1000;
    for (int k = 0; k < 9; k++) begin
      tick();
      i_req = (k < 8); d_req = (k < 8); d_we = 1'b0; i_addr = 17'd20; d_addr = 17'd10;
      #3;
      if (k < 8) begin
        checks++; if (i_gnt !== pat[k] || d_gnt !== ~pat[k]) begin errors++; $display("FAIL conflict_gnt k=%0d got i=%0b d=%0b exp i=%0b", k, i_gnt, d_gnt, pat[k]); end
      end
      if (k > 0) begin
        checks++; if (i_rvalid !== pat[k-1] || d_rvalid !== ~pat[k-1]) begin errors++; $display("FAIL conflict_rvalid k=%0d got i=%0b d=%0b exp i=%0b", k, i_rvalid, d_rvalid, pat[k-1]); end
        checks++; if (d_rdata !== (pat[k-1] ? 32'hA000_0014 : 32'hA000_000A)) begin errors++; $display("FAIL conflict_rdata k=%0d got %h", k, d_rdata); end
      end
      checks++; if (conflicts !== 32'(k)) begin errors++; $display("FAIL conflict_count k=%0d got %0d exp %0d", k, conflicts, k); end
    end
  endtask

  task automatic test_write_read();
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 17'd5; d_wdata = 32'hDEAD_BEEF; d_width = 3'b010;
    #3;
    checks++; if (d_gnt !== 1'b1 || m_we !== 1'b1 || m_addr !== 17'd5 || m_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_drive got gnt=%0b we=%0b addr=%0d data=%h", d_gnt, m_we, m_addr, m_wdata); end
    tick();
    d_we = 1'b0; d_width = 3'b101;
    #3;
    checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL wr_ack got %0b exp 1", d_rvalid); end
    checks++; if (d_gnt !== 1'b1 || m_we !== 1'b0 || m_width !== 3'b101) begin errors++; $display("FAIL rd_drive got gnt=%0b we=%0b w=%0b", d_gnt, m_we, m_width); end
    tick();
    d_req = 1'b0;
    #3;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got v=%0b %h exp 1 deadbeef", d_rvalid, d_rdata); end
  endtask

  task automatic test_halt();
    logic [3:0] pat;
    pat = 4'b1000;
    tick();
    i_req = 1'b1; i_addr = 17'd7;
    #3;
    checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL halt_pre_gnt got %0b exp 1", i_gnt); end
    for (int k = 0; k < 2; k++) begin
      tick();
      halt = 1'b1; d_req = 1'b1; d_we = 1'b1;
      #3;
      checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || m_we !== 1'b0) begin errors++; $display("FAIL halt_gnt k=%0d got i=%0b d=%0b we=%0b", k, i_gnt, d_gnt, m_we); end
      checks++; if (i_rvalid !== (k == 0)) begin errors++; $display("FAIL halt_rvalid k=%0d got %0b exp %0b", k, i_rvalid, k == 0); end
      if (k == 0) begin
        checks++; if (i_rdata !== 32'hA000_0007) begin errors++; $display("FAIL halt_rdata got %h exp a0000007", i_rdata); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      halt = 1'b0; d_we = 1'b0;
      #3;
      checks++; if (i_gnt !== pat[k] || d_gnt !== ~pat[k]) begin errors++; $display("FAIL halt_starve k=%0d got i=%0b d=%0b exp i=%0b", k, i_gnt, d_gnt, pat[k]); end
    end
    tick();
    i_req = 1'b0; d_req = 1'b0;
    #3;
    checks++; if (conflicts !== 32'd12) begin errors++; $display("FAIL halt_conflicts got %0d exp 12", conflicts); end
  endtask

  task automatic test_reset_mid();
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 17'd5;
    #3;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got %0b exp 1", d_gnt); end
    rst = 1'b0;
    #1;
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL mid_gnt_rst got %0b exp 0", d_gnt); end
    for (int k = 0; k < 2; k++) begin
      tick(); #3;
      checks++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid k=%0d got d=%0b i=%0b exp 0 0", k, d_rvalid, i_rvalid); end
    end
    checks++; if (conflicts !== 32'd0) begin errors++; $display("FAIL mid_conflicts got %0d exp 0", conflicts); end
    tick();
    rst = 1'b1; d_req = 1'b0;
    tick(); #3;
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL mid_post_rvalid got %0b exp 0", d_rvalid); end
  endtask

  initial begin
    test_reset();
    test_solo_fetch();
    test_conflict();
    test_write_read();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
